stopwatch_fsm: RTL and testbench
================================

// Module: stopwatch_fsm
// PURPOSE
//  Stopwatch core: an mm:ss BCD up-counter plus the start/pause/lap/reset state machine.
//  Consumes debounced one-pulse buttons and a 1 Hz enable tick.
//  Produces the count value q and the is_pause/is_restart/is_lap status flags.
//  Sits directly upstream of the LED control and seven-segment display stages.
// PARAMETERS
//  LIMIT  16'h5959  BCD saturation value {m10,m1,s10,s1}; reaching it ends the run.
// PORTS
//  clk          in   1   system clock; single clock domain
//  rst_n        in   1   asynchronous, active-low reset
//  tick         in   1   1-cycle 1 Hz enable pulse
//  start_stop   in   1   1-cycle debounced pulse: start / pause / resume
//  lap_reset    in   1   1-cycle debounced pulse: lap freeze / unfreeze / clear
//  q            out  16  displayed BCD count {m10[15:12],m1[11:8],s10[7:4],s1[3:0]}
//  is_pause     out  1   high in PAUSE
//  is_restart   out  1   high while counting (RUN or LAP)
//  is_lap       out  1   high in LAP (display frozen)
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset (async assert, sync deassert by clk): state=IDLE, cnt=0, lap=0, q=16'h0000.
//    All flags are 0 during and after reset.
//  - States:
//    - IDLE: cnt=0.
//    - RUN: counting, display live.
//    - PAUSE: counting held.
//    - LAP: counting continues, display frozen.
//    - DONE: cnt held at LIMIT.
//  - Transitions are taken on the clk edge that samples the pulse; outputs update on that same edge.
//    - IDLE : start_stop -> RUN; lap_reset ignored.
//    - RUN  : start_stop -> PAUSE; lap_reset -> LAP (lap <= cnt value of that cycle).
//    - PAUSE: start_stop -> RUN; lap_reset -> IDLE (cnt <= 0).
//    - LAP  : lap_reset -> RUN (display live again); start_stop -> PAUSE (display live, lap dropped).
//    - DONE : lap_reset -> IDLE (cnt <= 0); start_stop ignored.
//  - Simultaneous start_stop and lap_reset: start_stop wins; lap_reset is discarded.
//  - Increment happens only when the *current* state is RUN or LAP and tick=1.
//    - A tick coincident with start_stop in RUN is counted, then the FSM enters PAUSE.
//    - A tick coincident with start_stop in PAUSE or IDLE is NOT counted.
//  - BCD increment, ripple carry within one cycle:
//    - s1 wraps 9->0 and carries;
//    - s10 wraps 5->0 and carries;
//    - m1 wraps 9->0 and carries;
//    - m10 increments.
//  - Saturation: when the incremented value equals LIMIT, cnt <= LIMIT and state <= DONE in the same edge.
//    - cnt never exceeds LIMIT and never wraps to 0.
//    - Applies in LAP too: the freeze is dropped and q shows LIMIT.
//  - Output mux: q = lap in LAP, else cnt.
//  - Flags:
//    - is_pause = (state==PAUSE);
//    - is_restart = (state==RUN || state==LAP);
//    - is_lap = (state==LAP).
//    - DONE: all flags 0; downstream detects q==LIMIT.
//  - Reset asserted mid-run: immediate return to IDLE/0 regardless of state; pending pulses are lost.
//  - Inputs are assumed clean 1-cycle pulses.
//    A pulse held high for N cycles acts as N pulses; upstream one-pulse logic guarantees N=1.
// TESTING
//  - Reset, then start_stop, then 75 ticks -> q=16'h0115, is_restart=1, is_pause=0, is_lap=0.
//  - At q=16'h0030, start_stop, then 5 ticks -> q stays 16'h0030, is_pause=1.
//    Then lap_reset -> q=16'h0000, all flags 0.
//  - At q=16'h0012: lap_reset, then 3 ticks -> q holds 16'h0012, is_lap=1.
//    Then lap_reset -> q=16'h0015, is_lap=0.
//  - Preload to 16'h5958 in RUN, then 2 ticks -> q=16'h5959 and stays there, flags 0.
//    start_stop ignored; lap_reset -> q=0.
//  - start_stop and lap_reset in the same cycle in RUN -> PAUSE, no lap captured.
//    tick with start_stop in RUN: q increments by 1 and is_pause=1.
//  - Drop rst_n asynchronously mid-LAP (no clk edge) -> q=0 and all flags 0 immediately.

Source files
------------

// File: rtl/stopwatch_fsm.sv
// Stopwatch core: mm:ss BCD up-counter with start/pause/lap/clear control FSM.
module stopwatch_fsm #(
    parameter logic [15:0] LIMIT = 16'h5959
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        start_stop,
    input  logic        lap_reset,
    output logic [15:0] q,
    output logic        is_pause,
    output logic        is_restart,
    output logic        is_lap
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned DIG_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        LAP   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  lap;
    logic [CNT_W-1:0]  lap_nxt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  q_nxt;
    logic              counting;
    logic              saturate;
    logic              is_pause_nxt;
    logic              is_restart_nxt;
    logic              is_lap_nxt;

    // One-second BCD increment with ripple carry s1 -> s10 -> m1 -> m10.
    function automatic logic [CNT_W-1:0] bcd_inc(input logic [CNT_W-1:0] v);
        logic [DIG_W-1:0] s1;
        logic [DIG_W-1:0] s10;
        logic [DIG_W-1:0] m1;
        logic [DIG_W-1:0] m10;
        s1  = v[3:0];
        s10 = v[7:4];
        m1  = v[11:8];
        m10 = v[15:12];
        if (s1 == DIG_W'(9)) begin
            s1 = '0;
            if (s10 == DIG_W'(5)) begin
                s10 = '0;
                if (m1 == DIG_W'(9)) begin
                    m1  = '0;
                    m10 = m10 + DIG_W'(1);
                end else begin
                    m1 = m1 + DIG_W'(1);
                end
            end else begin
                s10 = s10 + DIG_W'(1);
            end
        end else begin
            s1 = s1 + DIG_W'(1);
        end
        return {m10, m1, s10, s1};
    endfunction

    // Next-state, counter, lap capture and registered-output values.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        lap_nxt        = lap;
        cnt_inc        = bcd_inc(cnt);
        counting       = tick && ((state == RUN) || (state == LAP));
        saturate       = counting && (cnt_inc == LIMIT);
        q_nxt          = '0;
        is_pause_nxt   = 1'b0;
        is_restart_nxt = 1'b0;
        is_lap_nxt     = 1'b0;

        if (counting) begin
            cnt_nxt = cnt_inc;
        end

        if (saturate) begin
            // Reaching the limit overrides any button and ends the run.
            state_nxt = DONE;
            cnt_nxt   = LIMIT;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_stop) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (start_stop) begin
                        state_nxt = PAUSE;
                    end else if (lap_reset) begin
                        state_nxt = LAP;
                        lap_nxt   = cnt;
                    end
                end
                PAUSE: begin
                    if (start_stop) begin
                        state_nxt = RUN;
                    end else if (lap_reset) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
                LAP: begin
                    if (start_stop) begin
                        state_nxt = PAUSE;
                    end else if (lap_reset) begin
                        state_nxt = RUN;
                    end
                end
                DONE: begin
                    // start_stop has no effect here but still masks lap_reset.
                    if (lap_reset && !start_stop) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        // The frozen value only lives while in LAP.
        if (state_nxt != LAP) begin
            lap_nxt = '0;
        end

        q_nxt          = (state_nxt == LAP) ? lap_nxt : cnt_nxt;
        is_pause_nxt   = (state_nxt == PAUSE);
        is_restart_nxt = (state_nxt == RUN) || (state_nxt == LAP);
        is_lap_nxt     = (state_nxt == LAP);
    end

    // State, counter, lap and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            lap        <= '0;
            q          <= '0;
            is_pause   <= 1'b0;
            is_restart <= 1'b0;
            is_lap     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            lap        <= lap_nxt;
            q          <= q_nxt;
            is_pause   <= is_pause_nxt;
            is_restart <= is_restart_nxt;
            is_lap     <= is_lap_nxt;
        end
    end

endmodule

// File: tb/tb_stopwatch_fsm.sv
// Self-checking bench for stopwatch_fsm: vector table, directed corners, random vs model.
module tb_stopwatch_fsm;

    logic        clk;
    logic        rst_n;
    logic        tick;
    logic        start_stop;
    logic        lap_reset;
    logic [15:0] q;
    logic        is_pause;
    logic        is_restart;
    logic        is_lap;

    int pass_cnt  = 0;
    int total_cnt = 0;

    stopwatch_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .start_stop (start_stop),
        .lap_reset  (lap_reset),
        .q          (q),
        .is_pause   (is_pause),
        .is_restart (is_restart),
        .is_lap     (is_lap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ss;
        logic        lr;
        logic        tk;
        logic [15:0] q;
        logic        p;
        logic        r;
        logic        l;
    } vec_t;

    // Behavioural model: elapsed seconds as an integer, mode as a small code.
    localparam int MD_IDLE  = 0;
    localparam int MD_RUN   = 1;
    localparam int MD_PAUSE = 2;
    localparam int MD_LAP   = 3;
    localparam int MD_DONE  = 4;
    localparam int MAX_SECS = 59 * 60 + 59;

    int m_mode;
    int m_secs;
    int m_lap;

    function automatic logic [15:0] to_bcd(input int s);
        int mins;
        int secs;
        mins = s / 60;
        secs = s % 60;
        return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10)};
    endfunction

    task automatic model_step(input logic ss, input logic lr, input logic tk);
        bit counted;
        counted = tk && (m_mode == MD_RUN || m_mode == MD_LAP);
        if (counted) m_secs = m_secs + 1;
        if (counted && m_secs == MAX_SECS) begin
            m_mode = MD_DONE;
        end else if (ss) begin
            if (m_mode == MD_IDLE || m_mode == MD_PAUSE) m_mode = MD_RUN;
            else if (m_mode == MD_RUN || m_mode == MD_LAP) m_mode = MD_PAUSE;
        end else if (lr) begin
            if (m_mode == MD_RUN) begin
                m_mode = MD_LAP;
                m_lap  = counted ? m_secs - 1 : m_secs;
            end else if (m_mode == MD_LAP) begin
                m_mode = MD_RUN;
            end else if (m_mode == MD_PAUSE || m_mode == MD_DONE) begin
                m_mode = MD_IDLE;
                m_secs = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [15:0] eq, input logic ep,
                         input logic er, input logic el);
        total_cnt++;
        if (q === eq && is_pause === ep && is_restart === er && is_lap === el) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got q=%h pause=%b restart=%b lap=%b, want q=%h pause=%b restart=%b lap=%b",
                     name, q, is_pause, is_restart, is_lap, eq, ep, er, el);
        end
    endtask

    // Apply one cycle of inputs; returns at posedge+1 with inputs cleared.
    task automatic cycle(input logic ss, input logic lr, input logic tk);
        start_stop = ss;
        lap_reset  = lr;
        tick       = tk;
        @(posedge clk);
        #1;
        start_stop = 1'b0;
        lap_reset  = 1'b0;
        tick       = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        tick       = 1'b0;
        start_stop = 1'b0;
        lap_reset  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_mode = MD_IDLE;
        m_secs = 0;
        m_lap  = 0;
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0}; // IDLE -> RUN
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b1, 1'b1}; // lap freeze
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 16'h0004, 1'b0, 1'b1, 1'b0}; // unfreeze, live
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 16'h0004, 1'b1, 1'b0, 1'b0}; // both: pause
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 16'h0004, 1'b1, 1'b0, 1'b0}; // paused tick
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 16'h0004, 1'b0, 1'b1, 1'b0}; // resume, tick lost
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b0, 1'b0}; // tick counted, pause
        vecs[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0}; // clear
        vecs[11] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0}; // ignored in IDLE
        vecs[12] = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0}; // start, tick lost

        rst_n      = 1'b0;
        tick       = 1'b0;
        start_stop = 1'b0;
        lap_reset  = 1'b0;
        #12;
        check("reset_hold", 16'h0000, 1'b0, 1'b0, 1'b0);
        do_reset();
        check("after_reset", 16'h0000, 1'b0, 1'b0, 1'b0);

        // Table-driven vectors
        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].ss, vecs[i].lr, vecs[i].tk);
            check($sformatf("vec%0d", i), vecs[i].q, vecs[i].p, vecs[i].r, vecs[i].l);
        end

        // 75 seconds of running
        do_reset();
        cycle(1'b1, 1'b0, 1'b0);
        ticks(75);
        check("run_75", 16'h0115, 1'b0, 1'b1, 1'b0);

        // Pause holds, clear from pause
        do_reset();
        cycle(1'b1, 1'b0, 1'b0);
        ticks(30);
        check("at_30", 16'h0030, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        ticks(5);
        check("pause_hold", 16'h0030, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        check("pause_clear", 16'h0000, 1'b0, 1'b0, 1'b0);

        // Lap freeze and release
        do_reset();
        cycle(1'b1, 1'b0, 1'b0);
        ticks(12);
        cycle(1'b0, 1'b1, 1'b0);
        ticks(3);
        check("lap_frozen", 16'h0012, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        check("lap_release", 16'h0015, 1'b0, 1'b1, 1'b0);

        // Saturation from RUN
        do_reset();
        cycle(1'b1, 1'b0, 1'b0);
        ticks(3598);
        check("pre_limit", 16'h5958, 1'b0, 1'b1, 1'b0);
        ticks(1);
        check("limit", 16'h5959, 1'b0, 1'b0, 1'b0);
        ticks(1);
        check("limit_hold", 16'h5959, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        check("done_ss_ignored", 16'h5959, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        check("done_clear", 16'h0000, 1'b0, 1'b0, 1'b0);

        // Saturation while in LAP drops the freeze
        do_reset();
        cycle(1'b1, 1'b0, 1'b0);
        ticks(3597);
        cycle(1'b0, 1'b1, 1'b0);
        ticks(1);
        check("lap_near_limit", 16'h5957, 1'b0, 1'b1, 1'b1);
        ticks(1);
        check("lap_limit", 16'h5959, 1'b0, 1'b0, 1'b0);

        // Simultaneous buttons in RUN: no lap captured
        do_reset();
        cycle(1'b1, 1'b0, 1'b0);
        ticks(7);
        cycle(1'b1, 1'b1, 1'b0);
        check("both_pause", 16'h0007, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        check("both_resume", 16'h0007, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        check("tick_with_ss", 16'h0008, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-LAP
        do_reset();
        cycle(1'b1, 1'b0, 1'b0);
        ticks(9);
        cycle(1'b0, 1'b1, 1'b0);
        ticks(2);
        check("lap_before_rst", 16'h0009, 1'b0, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("after_async_rst", 16'h0000, 1'b0, 1'b0, 1'b0);

        // Random pulses against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic ss;
            logic lr;
            logic tk;
            logic [15:0] eq;
            tk = ($urandom_range(1, 0) == 1);
            ss = ($urandom_range(15, 0) == 0);
            lr = ($urandom_range(11, 0) == 0);
            cycle(ss, lr, tk);
            model_step(ss, lr, tk);
            eq = (m_mode == MD_LAP) ? to_bcd(m_lap) : to_bcd(m_secs);
            check($sformatf("rand%0d", i), eq, 1'(m_mode == MD_PAUSE),
                  1'(m_mode == MD_RUN || m_mode == MD_LAP), 1'(m_mode == MD_LAP));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
